// File: rtl/edram_bank_ctrl.sv
// edram_bank_ctrl: one eDRAM bank with an open-row controller.
//   Serves single-beat reads/writes over a valid/ready handshake. Writes are
//   byte-enabled. Activate and precharge are timed cycle-accurately. The bank
//   runs periodic auto-refresh and has a self-refresh sleep mode.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake; req_we selects write
//   req_addr          {row, col}; req_wdata/req_be write data and byte enables
//   rsp_valid/rdata   one-cycle read response (rdata is 0 when not valid)
//   sleep_req/ack     self-refresh sleep request / acknowledge (high in SLEEP)
//   row_open/open_row currently open row (open_row is 0 when none is open)
//   ref_overflow      sticky: refresh interval expired with a refresh still pending
module edram_bank_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ROWS         = 256,
  parameter int unsigned COLS         = 8,
  parameter int unsigned TRCD         = 2,
  parameter int unsigned TRP          = 2,
  parameter int unsigned TRFC         = 4,
  parameter int unsigned REF_INTERVAL = 512,
  localparam int unsigned ROW_W  = $clog2(ROWS),
  localparam int unsigned COL_W  = $clog2(COLS),
  localparam int unsigned ADDR_W = ROW_W + COL_W,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              sleep_req,
  output logic              sleep_ack,
  output logic              row_open,
  output logic [ROW_W-1:0]  open_row,
  output logic              ref_overflow
);

  localparam int unsigned TMAX  = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                               : ((TRP > TRFC) ? TRP : TRFC);
  localparam int unsigned TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned RC_W  = $clog2(REF_INTERVAL);

  typedef enum logic [2:0] {IDLE, ACT, OPEN, PRE, REF, SLEEP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RC_W-1:0]    ref_cnt;
  logic [ROW_W-1:0]   ref_row;
  logic               ref_pending;
  logic               miss_q;
  logic               from_sleep_q;

  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [BE_W-1:0]    lat_be;

  logic [DATA_W-1:0]  mem [0:ROWS*COLS-1];

  logic               accept, hit, act_done, pre_done;
  logic               ref_wrap, ref_enter, pre_enter;
  logic               mem_we, mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [BE_W-1:0]    mem_be;

  assign sleep_ack = (state_q == SLEEP);

  always_comb begin
    // Ready is also gated by rst_n so it reads 0 while reset is held.
    req_ready = rst_n && (state_q == IDLE || state_q == OPEN) &&
                !ref_pending && !sleep_req;
    accept    = req_valid && req_ready;
    hit       = (state_q == OPEN) && (req_addr[ADDR_W-1:COL_W] == open_row);
    act_done  = (state_q == ACT) && (tmr_q == '0);
    pre_done  = (state_q == PRE) && (tmr_q == '0);
    ref_wrap  = (ref_cnt == RC_W'(REF_INTERVAL - 1));

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ref_pending)    state_d = REF;
        else if (sleep_req) state_d = SLEEP;
        else if (accept)    state_d = ACT;
      end
      OPEN: begin
        if (ref_pending || sleep_req || (accept && !hit)) state_d = PRE;
      end
      ACT: begin
        if (tmr_q == '0) state_d = OPEN;
      end
      PRE: begin
        // A latched row miss must be completed before anything else.
        if (tmr_q == '0) begin
          if (miss_q)           state_d = ACT;
          else if (ref_pending) state_d = REF;
          else if (sleep_req)   state_d = SLEEP;
          else                  state_d = IDLE;
        end
      end
      REF: begin
        if (tmr_q == '0) state_d = (from_sleep_q && sleep_req) ? SLEEP : IDLE;
      end
      SLEEP: begin
        if (ref_pending)     state_d = REF;
        else if (!sleep_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ref_enter = (state_d == REF) && (state_q != REF);
    pre_enter = (state_d == PRE) && (state_q != PRE);

    // Timer is loaded with duration-1 on entry to a timed state and counts to 0.
    if (state_d != state_q) begin
      case (state_d)
        ACT:     tmr_d = TMR_W'(TRCD - 1);
        PRE:     tmr_d = TMR_W'(TRP - 1);
        REF:     tmr_d = TMR_W'(TRFC - 1);
        default: tmr_d = '0;
      endcase
    end else begin
      tmr_d = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    end

    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_be    = lat_be;
    if (accept && hit) begin
      mem_we    = req_we;
      mem_rd    = !req_we;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
      mem_be    = req_be;
    end else if (act_done) begin
      mem_we = lat_we;
      mem_rd = !lat_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      ref_cnt      <= '0;
      ref_row      <= '0;
      ref_pending  <= 1'b0;
      ref_overflow <= 1'b0;
      miss_q       <= 1'b0;
      from_sleep_q <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      row_open     <= 1'b0;
      open_row     <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

      // A new expiry wins over a same-edge service.
      if (ref_wrap)       ref_pending <= 1'b1;
      else if (ref_enter) ref_pending <= 1'b0;
      if (ref_wrap && ref_pending && !ref_enter) ref_overflow <= 1'b1;

      if (ref_enter) begin
        ref_row      <= ref_row + 1'b1;
        from_sleep_q <= (state_q == SLEEP);
      end

      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end

      if (accept && (state_q == OPEN) && !hit) miss_q <= 1'b1;
      else if (pre_done)                       miss_q <= 1'b0;

      if (pre_enter) begin
        row_open <= 1'b0;
        open_row <= '0;
      end else if (act_done) begin
        row_open <= 1'b1;
        open_row <= lat_addr[ADDR_W-1:COL_W];
      end

      rsp_valid <= mem_rd;
      rsp_rdata <= mem_rd ? mem[mem_addr] : '0;
    end
  end

  // Array contents survive reset; an access dropped by reset never writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_edram_bank_ctrl.sv
// tb_edram_bank_ctrl: self-checking bench for edram_bank_ctrl.
//   Read responses are checked by a scoreboard (data and latency pushed at
//   acceptance, popped on rsp_valid); each scenario task checks its own
//   handshake, row and sleep observations inline.
module tb_edram_bank_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ROWS    = 256;
  localparam int unsigned COLS    = 8;
  localparam int unsigned TRCD    = 2;
  localparam int unsigned TRP     = 2;
  localparam int unsigned TRFC    = 4;
  // Shortened interval so a full 256-refresh pointer wrap fits the run.
  localparam int unsigned REF_INT = 128;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned BE_W    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [BE_W-1:0]   req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sleep_req = 1'b0;
  logic              sleep_ack;
  logic              row_open;
  logic [7:0]        open_row;
  logic              ref_overflow;

  edram_bank_ctrl #(
    .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .TRCD(TRCD), .TRP(TRP),
    .TRFC(TRFC), .REF_INTERVAL(REF_INT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sleep_req(sleep_req),
    .sleep_ack(sleep_ack), .row_open(row_open), .open_row(open_row),
    .ref_overflow(ref_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [int];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.data || (cyc - e.acc) !== e.lat)
          $display("FAIL rsp: got data=%h latency=%0d, required data=%h latency=%0d",
                   rsp_rdata, cyc - e.acc, e.data, e.lat);
        else n_pass++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, required run completion");
    $fatal(1);
  end

  // Drives one request until accepted; updates the model and the scoreboard.
  // Entered and left at posedge+1.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int lat, input bit push, output bit ok, output int acc);
    exp_t        e;
    logic [31:0] w;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    ok = 1'b0; acc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1; acc = cyc; break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      if (we) begin
        w = mdl.exists(int'(addr)) ? mdl[int'(addr)] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        mdl[int'(addr)] = w;
      end else if (push) begin
        e.data = mdl.exists(int'(addr)) ? mdl[int'(addr)] : 32'hx;
        e.acc = acc; e.lat = lat;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 1'b0; sleep_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [44:0] got;
    rst_n = 1'b0; req_valid = 1'b0; sleep_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {req_ready, rsp_valid, sleep_ack, row_open, ref_overflow, open_row, rsp_rdata};
    n_checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h, required 0", got);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, row_open, dut.ref_row} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL reset_release: got ready=%b row_open=%b ref_row=%0d, required 1 0 0",
               req_ready, row_open, dut.ref_row);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_access();
    bit ok, dok; int acc, lows;
    apply_reset();
    issue(1'b1, 11'h008, 32'hDEADBEEF, 4'hF, 0, 1'b0, ok, acc);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (!ok || row_open !== 1'b1 || open_row !== 8'd1)
      $display("FAIL idle_write: got ok=%b row_open=%b open_row=%0d, required 1 1 1",
               ok, row_open, open_row);
    else n_pass++;
    @(posedge clk); #1;
    apply_reset();
    issue(1'b0, 11'h008, 32'h0, 4'h0, TRCD + 1, 1'b1, ok, acc);
    lows = 0;
    for (int i = 0; i < TRCD; i++) begin
      @(negedge clk);
      if (req_ready === 1'b0) lows++;
    end
    n_checks++;
    if (!ok || lows !== TRCD)
      $display("FAIL idle_read_act: got ok=%b ready_low=%0d, required 1 %0d", ok, lows, TRCD);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({req_ready, row_open, open_row} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL idle_read_open: got ready=%b row_open=%b open_row=%0d, required 1 1 1",
               req_ready, row_open, open_row);
    else n_pass++;
    @(posedge clk); #1;
    drain(dok);
    n_checks++;
    if (!dok) $display("FAIL idle_read_drain: got %0d outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_row_hit();
    bit ok1, ok2, ok3, dok; int acc;
    issue(1'b1, 11'h009, 32'h00000000, 4'hF, 0, 1'b0, ok1, acc);
    issue(1'b1, 11'h009, 32'h11223344, 4'h5, 0, 1'b0, ok2, acc);
    issue(1'b0, 11'h009, 32'h0, 4'h0, 1, 1'b1, ok3, acc);
    drain(dok);
    n_checks++;
    if (!(ok1 && ok2 && ok3 && dok) || mdl[9] !== 32'h00220044)
      $display("FAIL row_hit: got ok=%b%b%b drain=%b model=%h, required 1111 00220044",
               ok1, ok2, ok3, dok, mdl[9]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({row_open, open_row, req_ready} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL row_hit_open: got row_open=%b open_row=%0d ready=%b, required 1 1 1",
               row_open, open_row, req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok, dok; int acc, first;
    all_ok = 1'b1;
    issue(1'b1, 11'h00A, 32'hAAAAAAAA, 4'hF, 0, 1'b0, ok, first); all_ok &= ok;
    issue(1'b1, 11'h00A, 32'h55667788, 4'h2, 0, 1'b0, ok, acc);   all_ok &= ok;
    issue(1'b0, 11'h00A, 32'h0, 4'h0, 1, 1'b1, ok, acc);          all_ok &= ok;
    issue(1'b0, 11'h008, 32'h0, 4'h0, 1, 1'b1, ok, acc);          all_ok &= ok;
    issue(1'b0, 11'h009, 32'h0, 4'h0, 1, 1'b1, ok, acc);          all_ok &= ok;
    n_checks++;
    if (!all_ok || (acc - first) !== 4)
      $display("FAIL back_to_back_accept: got ok=%b span=%0d, required 1 4", all_ok, acc - first);
    else n_pass++;
    drain(dok);
    n_checks++;
    if (!dok || mdl[10] !== 32'hAAAA77AA)
      $display("FAIL back_to_back_drain: got drain=%b model=%h, required 1 AAAA77AA", dok, mdl[10]);
    else n_pass++;
  endtask

  task automatic test_row_miss();
    bit ok1, ok2, ok3, dok; int acc, lows;
    logic ro1;
    issue(1'b1, 11'h010, 32'hCAFEF00D, 4'hF, 0, 1'b0, ok1, acc);
    issue(1'b0, 11'h008, 32'h0, 4'h0, TRP + TRCD + 1, 1'b1, ok2, acc);
    issue(1'b0, 11'h010, 32'h0, 4'h0, TRP + TRCD + 1, 1'b1, ok3, acc);
    lows = 0; ro1 = 1'bx;
    for (int i = 0; i < TRP + TRCD; i++) begin
      @(negedge clk);
      if (i == 0) ro1 = row_open;
      if (req_ready === 1'b0) lows++;
    end
    n_checks++;
    if (!(ok1 && ok2 && ok3) || lows !== TRP + TRCD || ro1 !== 1'b0)
      $display("FAIL row_miss_busy: got ok=%b%b%b ready_low=%0d row_open_in_pre=%b, required 111 %0d 0",
               ok1, ok2, ok3, lows, ro1, TRP + TRCD);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({req_ready, row_open, open_row} !== {1'b1, 1'b1, 8'd2})
      $display("FAIL row_miss_open: got ready=%b row_open=%b open_row=%0d, required 1 1 2",
               req_ready, row_open, open_row);
    else n_pass++;
    @(posedge clk); #1;
    drain(dok);
    n_checks++;
    if (!dok) $display("FAIL row_miss_drain: got %0d outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_refresh();
    int drop, lows, win;
    logic prev;
    apply_reset();
    drop = -1;
    for (int i = 0; i < REF_INT + 16; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b1) begin drop = i; break; end
    end
    n_checks++;
    if (drop !== REF_INT)
      $display("FAIL refresh_start: got ready drop at cycle %0d, required %0d", drop, REF_INT);
    else n_pass++;
    // One pending cycle in IDLE, then TRFC cycles of REF.
    lows = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      lows++;
    end
    n_checks++;
    if (lows !== 1 + TRFC || dut.ref_row !== 8'd1)
      $display("FAIL refresh_window: got ready_low=%0d ref_row=%0d, required %0d 1",
               lows, dut.ref_row, 1 + TRFC);
    else n_pass++;
    prev = 1'b1; win = 0;
    for (int i = 0; i < 255 * REF_INT + 200; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && req_ready === 1'b0) win++;
      prev = req_ready;
      if (win == 255 && req_ready === 1'b1) break;
    end
    n_checks++;
    if (win !== 255 || dut.ref_row !== 8'd0 || ref_overflow !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL refresh_wrap: got windows=%0d ref_row=%0d overflow=%b rdata=%h, required 255 0 0 0",
               win, dut.ref_row, ref_overflow, rsp_rdata);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_sleep();
    bit ok, dok, fell; int acc, lows;
    logic [2:0] s1, s2;
    apply_reset();
    issue(1'b0, 11'h010, 32'h0, 4'h0, TRCD + 1, 1'b1, ok, acc);
    drain(dok);
    n_checks++;
    if (!ok || !dok || open_row !== 8'd2)
      $display("FAIL sleep_setup: got ok=%b drain=%b open_row=%0d, required 1 1 2", ok, dok, open_row);
    else n_pass++;
    sleep_req = 1'b1;
    @(negedge clk); s1[0] = req_ready;
    @(negedge clk); s1[1] = row_open | sleep_ack;
    @(negedge clk); s1[2] = sleep_ack;
    @(negedge clk);
    s2 = {sleep_ack, row_open, |open_row};
    n_checks++;
    if (s1 !== 3'b000 || s2 !== 3'b100)
      $display("FAIL sleep_entry: got pre=%b sleep=%b, required 000 100", s1, s2);
    else n_pass++;
    fell = 1'b0;
    for (int i = 0; i < 2 * REF_INT; i++) begin
      @(negedge clk);
      if (sleep_ack !== 1'b1) begin fell = 1'b1; break; end
    end
    lows = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sleep_ack === 1'b1) break;
      lows++;
    end
    n_checks++;
    if (!fell || lows !== TRFC || dut.ref_row !== 8'd1 || sleep_ack !== 1'b1)
      $display("FAIL sleep_refresh: got fell=%b ref_len=%0d ref_row=%0d ack=%b, required 1 %0d 1 1",
               fell, lows, dut.ref_row, sleep_ack, TRFC);
    else n_pass++;
    @(posedge clk); #1 sleep_req = 1'b0;
    @(negedge clk); s1[1:0] = {sleep_ack, req_ready};
    @(negedge clk); s2[1:0] = {sleep_ack, req_ready};
    n_checks++;
    if (s1[1:0] !== 2'b10 || s2[1:0] !== 2'b01)
      $display("FAIL sleep_exit: got {ack,ready} %b then %b, required 10 then 01", s1[1:0], s2[1:0]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_act();
    bit ok; int acc, seen;
    logic in_act_ready;
    apply_reset();
    issue(1'b0, 11'h008, 32'h0, 4'h0, 0, 1'b0, ok, acc);
    @(negedge clk);
    in_act_ready = req_ready;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!ok || in_act_ready !== 1'b0 ||
        {req_ready, row_open, rsp_valid, open_row} !== {1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset_mid_act: got ok=%b act_ready=%b ready=%b row_open=%b rsp=%b open_row=%0d, required 1 0 1 0 0 0",
               ok, in_act_ready, req_ready, row_open, rsp_valid, open_row);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_act_rsp: got %0d response cycles, required 0", seen);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_idle_access();
    test_row_hit();
    test_back_to_back();
    test_row_miss();
    test_refresh();
    test_sleep();
    test_reset_mid_act();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
